bk_kbd_ctrl: RTL



---
 rtl/bk_kbd_ctrl_if.sv | 28 ++
 rtl/bk_kbd_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bk_kbd_ctrl_if.sv
// Keyboard front-end bus bundle.
//   master : PS/2 receiver + CPU side (drives scan bytes and the read strobe)
//   slave  : bk_kbd_ctrl (drives FIFO head and key status)
// Signals:
//   scan_code[7:0], scan_valid  : set-2 scan byte and its one-cycle strobe
//   read_kbd                    : high while the CPU addresses 0177662
//   kbd_data[7:0], kbd_available, kbd_ar2 : FIFO head
//   stopkey, keydown            : F12 held / last queued key held
interface bk_kbd_ctrl_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       read_kbd;
  logic [7:0] kbd_data;
  logic       kbd_available;
  logic       kbd_ar2;
  logic       stopkey;
  logic       keydown;

  modport master (
    output scan_code, scan_valid, read_kbd,
    input  kbd_data, kbd_available, kbd_ar2, stopkey, keydown
  );

  modport slave (
    input  scan_code, scan_valid, read_kbd,
    output kbd_data, kbd_available, kbd_ar2, stopkey, keydown
  );
endinterface

// File: rtl/bk_kbd_ctrl.sv
// bk_kbd_ctrl: PS/2 set-2 scan codes -> BK KOI-7 key codes, queued in a FIFO.
// Ports:
//   m_clock : system clock
//   p_reset : asynchronous active-high reset
//   kbd     : bk_kbd_ctrl_if.slave (scan input, read strobe, FIFO head, status)
// Pipeline: the scan byte is decoded/translated into push_q/push_ent on the
// strobe edge; the next edge writes the FIFO and refreshes the registered head.
module bk_kbd_ctrl #(
  parameter int DEPTH   = 4,
  parameter int SKIP_E1 = 7
) (
  input  logic         m_clock,
  input  logic         p_reset,
  bk_kbd_ctrl_if.slave kbd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SKIP_E1 + 1);

  typedef struct packed {
    logic       ar2;
    logic [7:0] code;
  } kbd_ent_t;

  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP} st_t;

  // Returns {valid, code}; valid=0 for unmapped keys.
  function automatic logic [8:0] xlat(input logic ext, input logic [7:0] sc,
                                      input logic shift, input logic ctrl);
    logic       lv, dv;
    logic [4:0] n;
    logic [3:0] d;
    logic [8:0] r;
    r = '0; lv = 1'b1; dv = 1'b1; n = '0; d = '0;
    case (sc)
      8'h1C: n = 5'd0;  8'h32: n = 5'd1;  8'h21: n = 5'd2;  8'h23: n = 5'd3;
      8'h24: n = 5'd4;  8'h2B: n = 5'd5;  8'h34: n = 5'd6;  8'h33: n = 5'd7;
      8'h43: n = 5'd8;  8'h3B: n = 5'd9;  8'h42: n = 5'd10; 8'h4B: n = 5'd11;
      8'h3A: n = 5'd12; 8'h31: n = 5'd13; 8'h44: n = 5'd14; 8'h4D: n = 5'd15;
      8'h15: n = 5'd16; 8'h2D: n = 5'd17; 8'h1B: n = 5'd18; 8'h2C: n = 5'd19;
      8'h3C: n = 5'd20; 8'h2A: n = 5'd21; 8'h1D: n = 5'd22; 8'h22: n = 5'd23;
      8'h35: n = 5'd24; 8'h1A: n = 5'd25;
      default: lv = 1'b0;
    endcase
    case (sc)
      8'h45: d = 4'd0; 8'h16: d = 4'd1; 8'h1E: d = 4'd2; 8'h26: d = 4'd3;
      8'h25: d = 4'd4; 8'h2E: d = 4'd5; 8'h36: d = 4'd6; 8'h3D: d = 4'd7;
      8'h3E: d = 4'd8; 8'h46: d = 4'd9;
      default: dv = 1'b0;
    endcase
    if (ext) begin
      case (sc)
        8'h75:   r = {1'b1, 8'o032};
        8'h72:   r = {1'b1, 8'o033};
        8'h6B:   r = {1'b1, 8'o010};
        8'h74:   r = {1'b1, 8'o031};
        default: r = '0;
      endcase
    end else if (lv) begin
      r = {1'b1, ctrl  ? 8'h01 + {3'b0, n} :
                 shift ? 8'h61 + {3'b0, n} : 8'h41 + {3'b0, n}};
    end else if (dv) begin
      r = {1'b1, (shift && d != 4'd0) ? 8'h20 + {4'b0, d} : 8'h30 + {4'b0, d}};
    end else begin
      case (sc)
        8'h5A:   r = {1'b1, 8'o012};
        8'h29:   r = {1'b1, 8'o040};
        8'h66:   r = {1'b1, 8'o030};
        8'h0D:   r = {1'b1, 8'o011};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // ---------------- prefix FSM / decode ----------------
  st_t           st, st_n;
  logic [CW-1:0] skip_cnt, cnt_n;
  logic          make_v, brk_v, key_ext;
  logic [8:0]    key, last_key, xl;
  logic          shift, ctrl, ar2, stopkey, keydown;
  logic          is_shift, is_ctrl, is_ar2, is_stop;
  logic          push_q, rd_q;
  kbd_ent_t      push_ent;

  always_comb begin
    st_n    = st;
    cnt_n   = skip_cnt;
    make_v  = 1'b0;
    brk_v   = 1'b0;
    key_ext = 1'b0;
    if (kbd.scan_valid) begin
      unique case (st)
        ST_IDLE: begin
          if (kbd.scan_code == 8'hE0)      st_n = ST_EXT;
          else if (kbd.scan_code == 8'hF0) st_n = ST_BRK;
          else if (kbd.scan_code == 8'hE1) begin
            st_n  = ST_SKIP;
            cnt_n = CW'(SKIP_E1);
          end else make_v = 1'b1;
        end
        ST_EXT: begin
          if (kbd.scan_code == 8'hF0) st_n = ST_EXT_BRK;
          else begin
            make_v  = 1'b1;
            key_ext = 1'b1;
            st_n    = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_v = 1'b1;
          st_n  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_v   = 1'b1;
          key_ext = 1'b1;
          st_n    = ST_IDLE;
        end
        ST_SKIP: begin
          cnt_n = skip_cnt - CW'(1);
          if (skip_cnt <= CW'(1)) st_n = ST_IDLE;
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  assign key      = {key_ext, kbd.scan_code};
  assign xl       = xlat(key_ext, kbd.scan_code, shift, ctrl);
  assign is_shift = !key_ext && (kbd.scan_code == 8'h12 || kbd.scan_code == 8'h59);
  assign is_ctrl  = kbd.scan_code == 8'h14;
  assign is_ar2   = kbd.scan_code == 8'h11;
  assign is_stop  = !key_ext && kbd.scan_code == 8'h07;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      st       <= ST_IDLE;
      skip_cnt <= '0;
      shift    <= 1'b0;
      ctrl     <= 1'b0;
      ar2      <= 1'b0;
      stopkey  <= 1'b0;
      keydown  <= 1'b0;
      last_key <= '0;
      push_q   <= 1'b0;
      push_ent <= '0;
      rd_q     <= 1'b0;
    end else begin
      st       <= st_n;
      skip_cnt <= cnt_n;
      rd_q     <= kbd.read_kbd;
      push_q   <= 1'b0;
      if (make_v) begin
        if (is_shift)     shift   <= 1'b1;
        else if (is_ctrl) ctrl    <= 1'b1;
        else if (is_ar2)  ar2     <= 1'b1;
        else if (is_stop) stopkey <= 1'b1;
        else if (xl[8]) begin
          last_key <= key;
          keydown  <= 1'b1;
          push_q   <= 1'b1;
          push_ent <= '{ar2: ar2, code: xl[7:0]};
        end
      end
      if (brk_v) begin
        if (is_shift)     shift   <= 1'b0;
        if (is_ctrl)      ctrl    <= 1'b0;
        if (is_ar2)       ar2     <= 1'b0;
        if (is_stop)      stopkey <= 1'b0;
        if (key == last_key) keydown <= 1'b0;
      end
    end
  end

  // ---------------- FIFO ----------------
  kbd_ent_t          mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_n;
  logic [AW:0]       count, count_n;
  logic              pop, push_ok;
  kbd_ent_t          head, head_n;

  assign pop     = rd_q && !kbd.read_kbd && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_q && ((count != (AW+1)'(DEPTH)) || pop);
  assign rd_n    = rd_ptr + AW'(pop);
  assign count_n = count + (AW+1)'(push_ok) - (AW+1)'(pop);

  // Head after this edge; bypass the entry being written when it lands at
  // the new read pointer (push into empty, or push+pop at count 1).
  always_comb begin
    head_n = '0;
    if (count_n != '0)
      head_n = (push_ok && wr_ptr == rd_n) ? push_ent : mem[rd_n];
  end

  always_ff @(posedge m_clock) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_n;
      count  <= count_n;
      head   <= head_n;
    end
  end

  assign kbd.kbd_data      = head.code;
  assign kbd.kbd_ar2       = head.ar2;
  assign kbd.kbd_available = (count != '0);
  assign kbd.stopkey       = stopkey;
  assign kbd.keydown       = keydown;
endmodule
